nibble_serial_adder_seq: RTL and testbench

- Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one 4-bit carry-lookahead adder slice (74S283-equivalent), one nibble per clock, LSB nibble first.
- Used where a wide add is not latency-critical and a single 4-bit slice is shared across cycles, e.g. microcode-driven address/count arithmetic.
- Holds operands in shift registers and carries between nibbles in a flop.
- Presents a req/busy/done handshake to the issuing logic.

---
 rtl/nibble_seq_pkg.sv | 12 +
 rtl/nibble_cla_slice.sv | 21 ++
 rtl/nibble_serial_adder_seq.sv | 139 +++++++++++++
 tb/tb_nibble_serial_adder_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_seq_pkg.sv
// nibble_seq_pkg: state encoding and slice width shared by the nibble-serial adder.
package nibble_seq_pkg;
   localparam int NIBBLE_W = 4;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_t;
endpackage

// File: rtl/nibble_cla_slice.sv
// nibble_cla_slice: combinational 4-bit generate/propagate carry-lookahead adder (74S283-style).
module nibble_cla_slice
   import nibble_seq_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a4,
   input  logic [NIBBLE_W-1:0] b4,
   input  logic                c0,
   output logic [NIBBLE_W-1:0] s4,
   output logic                c4
);
   logic [NIBBLE_W-1:0] g, p;
   logic c1, c2, c3;
   assign g  = a4 & b4;
   assign p  = a4 ^ b4;
   assign c1 = g[0] | (p[0] & c0);
   assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
   assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
   assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
   assign s4 = p ^ {c3, c2, c1, c0};
endmodule

// File: rtl/nibble_serial_adder_seq.sv
// nibble_serial_adder_seq: WIDTH-bit add/subtract through one shared 4-bit CLA slice, one nibble per clock.
// Optional zero-result flag output enabled by NIBBLE_SEQ_ZERO_FLAG_EN.
module nibble_serial_adder_seq
   import nibble_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
`ifdef NIBBLE_SEQ_ZERO_FLAG_EN
   ,
   output logic             zero
`endif
);
   localparam int NIB = WIDTH / NIBBLE_W;
   localparam int IW  = $clog2(NIB);
   state_t state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_q, res_d, sum_q, sum_d;
   logic carry_q, carry_d, sign_a_q, sign_a_d, sign_b_q, sign_b_d;
   logic cout_q, cout_d, ovf_q, ovf_d;
   logic [NIBBLE_W-1:0] s;
   logic c4;
   nibble_cla_slice u_slice (
      .a4 (a_sh_q[NIBBLE_W-1:0]),
      .b4 (b_sh_q[NIBBLE_W-1:0]),
      .c0 (carry_q),
      .s4 (s),
      .c4 (c4)
   );
   wire last = (idx_q == IW'(NIB - 1));
`ifdef NIBBLE_SEQ_ZERO_FLAG_EN
   logic zacc_q, zacc_d, zero_q, zero_d;
`endif
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_d    = res_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
`ifdef NIBBLE_SEQ_ZERO_FLAG_EN
      zacc_d   = zacc_q;
      zero_d   = zero_q;
`endif
      if (state_q == S_IDLE && req) begin
         state_d  = S_RUN;
         idx_d    = '0;
         a_sh_d   = a;
         b_sh_d   = sub ? ~b : b;
         carry_d  = sub | cin;
         sign_a_d = a[WIDTH-1];
         sign_b_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
`ifdef NIBBLE_SEQ_ZERO_FLAG_EN
         zacc_d   = 1'b1;
`endif
      end else if (state_q == S_RUN) begin
         a_sh_d  = {{NIBBLE_W{1'b0}}, a_sh_q[WIDTH-1:NIBBLE_W]};
         b_sh_d  = {{NIBBLE_W{1'b0}}, b_sh_q[WIDTH-1:NIBBLE_W]};
         res_d   = {s, res_q[WIDTH-1:NIBBLE_W]};
         carry_d = c4;
         idx_d   = idx_q + 1'b1;
`ifdef NIBBLE_SEQ_ZERO_FLAG_EN
         zacc_d  = zacc_q & (s == '0);
`endif
         // Outputs only move on the last nibble so sum never shows a partial result.
         if (last) begin
            state_d = S_DONE;
            sum_d   = {s, res_q[WIDTH-1:NIBBLE_W]};
            cout_d  = c4;
            ovf_d   = (sign_a_q == sign_b_q) && (s[NIBBLE_W-1] != sign_a_q);
`ifdef NIBBLE_SEQ_ZERO_FLAG_EN
            zero_d  = zacc_q & (s == '0);
`endif
         end
      end else if (state_q == S_DONE) begin
         state_d = S_IDLE;
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_q    <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_q    <= res_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end
`ifdef NIBBLE_SEQ_ZERO_FLAG_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         zacc_q <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         zacc_q <= zacc_d;
         zero_q <= zero_d;
      end
   end
   assign zero = zero_q;
`endif
   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_seq.sv
// tb_nibble_serial_adder_seq: scoreboard bench for the nibble-serial adder sequencer.
module tb_nibble_serial_adder_seq;
   localparam int W = 32;
   logic clk = 1'b0;
   logic reset_n, req, sub, cin;
   logic [W-1:0] a, b, sum;
   logic busy, done, cout, ovf, zero;
   typedef struct {
      logic [W-1:0] sum;
      logic cout, ovf, zero;
   } exp_t;
   exp_t q[$];
   int n_tests = 0, n_fail = 0;

   nibble_serial_adder_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .sub(sub), .cin(cin), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
`ifdef NIBBLE_SEQ_ZERO_FLAG_EN
      , .zero(zero)
`endif
   );
`ifndef NIBBLE_SEQ_ZERO_FLAG_EN
   assign zero = 1'b0;
`endif

   always #5 clk = ~clk;

   // Drive one request (call at a negedge); the model result goes to the scoreboard when push=1.
   task automatic issue(input logic [W-1:0] ia, ib, input logic isub, icin, input bit push);
      logic [W-1:0] bb;
      logic [W:0] r;
      exp_t e;
      bb = isub ? ~ib : ib;
      r = {1'b0, ia} + {1'b0, bb} + (W+1)'(isub | icin);
      e.sum = r[W-1:0];
      e.cout = r[W];
      e.ovf = (ia[W-1] == bb[W-1]) && (r[W-1] != ia[W-1]);
      e.zero = (r[W-1:0] == '0);
      a = ia; b = ib; sub = isub; cin = icin; req = 1'b1;
      if (push) q.push_back(e);
   endtask

   task automatic wait_done(input bit keep, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!keep) req = 1'b0;
      end while (!done && lat < 40);
      if (!done) lat = -1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; req = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
      #1;
      n_tests++;
      if ({busy, done, cout, ovf, zero} !== 5'b0 || sum !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b zero=%b want all 0",
                  busy, done, sum, cout, ovf, zero);
      end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_arith();
      logic [W-1:0] va[8], vb[8];
      logic vs[8], vc[8];
      int lat;
      exp_t e;
      va = '{32'h0000000F, 32'hFFFFFFFF, 32'h80000000, 32'h00000003, 32'h12345678, 32'h7FFFFFFF, 32'h00000000, 32'h0};
      vb = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000005, 32'h11111111, 32'h00000001, 32'h00000000, 32'h0};
      vs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      vc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      va[7] = $urandom; vb[7] = $urandom;
      for (int i = 0; i < 8; i++) begin
         issue(va[i], vb[i], vs[i], vc[i], 1'b1);
         wait_done(1'b0, lat);
         n_tests++;
         if (lat !== 9) begin
            n_fail++;
            $display("FAIL arith_latency[%0d]: got %0d want 9", i, lat);
         end
         if (q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL arith_queue[%0d]: got empty want entry", i);
         end else begin
            e = q.pop_front();
            n_tests++;
            if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
               n_fail++;
               $display("FAIL arith_result[%0d]: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                        i, sum, cout, ovf, e.sum, e.cout, e.ovf);
            end
`ifdef NIBBLE_SEQ_ZERO_FLAG_EN
            n_tests++;
            if (zero !== e.zero) begin
               n_fail++;
               $display("FAIL arith_zero[%0d]: got %b want %b", i, zero, e.zero);
            end
`endif
         end
         @(negedge clk);
         n_tests++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL arith_done_pulse[%0d]: got done=%b busy=%b want 0 0", i, done, busy);
         end
      end
   endtask

   task automatic test_handshake();
      logic [W-1:0] prev;
      int c;
      exp_t e;
      prev = sum;
      issue(32'h01020304, 32'h10203040, 1'b0, 1'b0, 1'b1);
      for (c = 1; c <= 40; c++) begin
         @(negedge clk);
         req = (c == 2 || c == 5);
         if (req) begin a = 32'hDEADBEEF ^ c; b = 32'h55555555; sub = 1'b1; end
         if (done) break;
         n_tests++;
         if (sum !== prev) begin
            n_fail++;
            $display("FAIL hs_sum_stable[c%0d]: got %h want %h", c, sum, prev);
         end
      end
      req = 1'b0;
      n_tests++;
      if (c !== 9) begin
         n_fail++;
         $display("FAIL hs_latency: got %0d want 9", c);
      end
      e = q.pop_front();
      n_tests++;
      if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
         n_fail++;
         $display("FAIL hs_result: got %h/%b/%b want %h/%b/%b", sum, cout, ovf, e.sum, e.cout, e.ovf);
      end
      repeat (2) begin
         @(negedge clk);
         n_tests++;
         if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_not_queued: got busy=%b want 0", busy);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      exp_t e;
      issue(32'hAAAA5555, 32'h11112222, 1'b0, 1'b1, 1'b1);
      wait_done(1'b1, lat);
      n_tests++;
      if (lat !== 9) begin
         n_fail++;
         $display("FAIL b2b_first_latency: got %0d want 9", lat);
      end
      e = q.pop_front();
      n_tests++;
      if (sum !== e.sum || cout !== e.cout) begin
         n_fail++;
         $display("FAIL b2b_first: got %h/%b want %h/%b", sum, cout, e.sum, e.cout);
      end
      issue(32'h00000010, 32'h00000020, 1'b1, 1'b0, 1'b1);
      wait_done(1'b1, lat);
      req = 1'b0;
      n_tests++;
      if (lat !== 10) begin
         n_fail++;
         $display("FAIL b2b_gap: got %0d want 10", lat);
      end
      e = q.pop_front();
      n_tests++;
      if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
         n_fail++;
         $display("FAIL b2b_second: got %h/%b/%b want %h/%b/%b", sum, cout, ovf, e.sum, e.cout, e.ovf);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int lat;
      bit seen;
      exp_t e;
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
      repeat (5) begin
         @(negedge clk);
         req = 1'b0;
      end
      reset_n = 1'b0;
      #1;
      n_tests++;
      if ({busy, done, cout, ovf, zero} !== 5'b0 || sum !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                  busy, done, sum, cout, ovf);
      end
      @(negedge clk);
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      n_tests++;
      if (seen) begin
         n_fail++;
         $display("FAIL reset_mid_no_done: got activity=1 want 0");
      end
      issue(32'h12345678, 32'h11111111, 1'b0, 1'b1, 1'b1);
      wait_done(1'b0, lat);
      e = q.pop_front();
      n_tests++;
      if (lat !== 9 || sum !== e.sum || cout !== e.cout) begin
         n_fail++;
         $display("FAIL reset_mid_next_op: got lat=%0d %h/%b want lat=9 %h/%b", lat, sum, cout, e.sum, e.cout);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_arith();
      test_handshake();
      test_back_to_back();
      test_reset_mid();
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drained: got %0d left want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
